// File: rtl/mdio_master.sv
// ---------------------------------------------------------------------------
// mdio_master
//   IEEE 802.3 Clause-22 MDIO management master. Accepts one PHY register
//   access at a time and produces MDC from clk. It shifts out the preamble,
//   ST, OP, PHYAD, REGAD, TA and DATA fields MSB first. On reads it releases
//   mdio from the first turnaround bit onwards and samples the PHY's reply.
//
// Parameters
//   CLK_DIV       MDC half-period in clk cycles (>= 2)
//   PREAMBLE_LEN  number of leading '1' preamble bits (0..32)
//   TA_CHECK      1: flag err_o when the PHY leaves the 2nd TA bit high
//
// Ports
//   clk, rst_n    system clock, synchronous active-low reset
//   start_i       request, taken only while ready_o is high
//   mode_i        1 = read, 0 = write
//   phy_addr_i    PHY address
//   reg_addr_i    register address
//   data_i        write data
//   ready_o       idle / able to accept
//   done_o        one-cycle pulse when a frame ends
//   err_o         read turnaround error, held until the next accept
//   data_o        read data, refreshed only when a read completes
//   mdc_o         management clock to the PHY
//   mdio_io       bidirectional management data line
// ---------------------------------------------------------------------------
module mdio_master #(
  parameter int CLK_DIV      = 20,
  parameter int PREAMBLE_LEN = 32,
  parameter bit TA_CHECK     = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        mode_i,
  input  logic [4:0]  phy_addr_i,
  input  logic [4:0]  reg_addr_i,
  input  logic [15:0] data_i,
  output logic        ready_o,
  output logic        done_o,
  output logic        err_o,
  output logic [15:0] data_o,
  output logic        mdc_o,
  inout  wire         mdio_io
);

  localparam int               DIV_W     = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [5:0]       PRE_BITS  = 6'(PREAMBLE_LEN);
  localparam logic [5:0]       LAST_BIT  = 6'(PREAMBLE_LEN + 31);
  localparam logic [5:0]       TA2_BIT   = 6'(PREAMBLE_LEN + 15);
  // First bit index that a read leaves undriven (TA1).
  localparam logic [5:0]       RD_RELEASE = 6'(PREAMBLE_LEN + 14);

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA, S_DONE
  } state_t;

  state_t             state;
  logic [5:0]         bit_cnt;
  logic [DIV_W-1:0]   div_cnt;
  logic               rd_q;
  logic [4:0]         phy_q;
  logic [4:0]         reg_q;
  logic [15:0]        wdata_q;
  logic [15:0]        shift_q;
  logic               ta_q;
  logic               mdio_out_q;
  logic               mdio_oe_q;

  // Map the frame bit index onto the field being transferred.
  function automatic state_t phase_of(input logic [5:0] idx);
    logic [5:0] rel;
    rel = idx - PRE_BITS;
    if (idx < PRE_BITS)    return S_PRE;
    else if (rel < 6'd2)   return S_ST;
    else if (rel < 6'd4)   return S_OP;
    else if (rel < 6'd9)   return S_PHYAD;
    else if (rel < 6'd14)  return S_REGAD;
    else if (rel < 6'd16)  return S_TA;
    else                   return S_DATA;
  endfunction

  // Value driven for a given frame bit. Preamble bits are all ones. The
  // remaining 32 bits come from the assembled Clause-22 word, MSB first.
  // The read TA bits in this word are never driven.
  function automatic logic frame_bit(input logic [5:0]  idx,
                                     input logic        rd,
                                     input logic [4:0]  phy,
                                     input logic [4:0]  rga,
                                     input logic [15:0] dat);
    logic [31:0] frame;
    frame = {2'b01, (rd ? 2'b10 : 2'b01), phy, rga, 2'b10, dat};
    if (idx < PRE_BITS) return 1'b1;
    return frame[5'd31 - 5'(idx - PRE_BITS)];
  endfunction

  // Writes own the line for the whole frame. Reads give it up at TA1.
  function automatic logic frame_oe(input logic [5:0] idx, input logic rd);
    return !rd || (idx < RD_RELEASE);
  endfunction

  assign mdio_io = mdio_oe_q ? mdio_out_q : 1'bz;

  // Main sequencer. div_cnt splits each bit into a low and a high MDC half.
  // The end of the low half raises MDC and samples mdio. The end of the high
  // half either advances to the next bit, driving its value while MDC is
  // low, or closes the frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      ready_o    <= 1'b1;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      data_o     <= 16'h0;
      mdc_o      <= 1'b0;
      mdio_out_q <= 1'b1;
      mdio_oe_q  <= 1'b0;
      bit_cnt    <= 6'd0;
      div_cnt    <= '0;
      rd_q       <= 1'b0;
      phy_q      <= 5'd0;
      reg_q      <= 5'd0;
      wdata_q    <= 16'h0;
      shift_q    <= 16'h0;
      ta_q       <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done_o    <= 1'b0;
          mdc_o     <= 1'b0;
          mdio_oe_q <= 1'b0;
          // ready_o is high in both of these states, so a request is taken.
          if (start_i) begin
            rd_q       <= mode_i;
            phy_q      <= phy_addr_i;
            reg_q      <= reg_addr_i;
            wdata_q    <= data_i;
            err_o      <= 1'b0;
            ready_o    <= 1'b0;
            bit_cnt    <= 6'd0;
            div_cnt    <= '0;
            state      <= phase_of(6'd0);
            mdio_out_q <= frame_bit(6'd0, mode_i, phy_addr_i, reg_addr_i, data_i);
            mdio_oe_q  <= 1'b1;
          end else begin
            state   <= S_IDLE;
            ready_o <= 1'b1;
          end
        end

        default: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (!mdc_o) begin
              mdc_o <= 1'b1;
              if (bit_cnt == TA2_BIT) ta_q <= mdio_io;
              if (state == S_DATA) shift_q <= {shift_q[14:0], mdio_io};
            end else begin
              mdc_o <= 1'b0;
              if (bit_cnt == LAST_BIT) begin
                state     <= S_DONE;
                done_o    <= 1'b1;
                ready_o   <= 1'b1;
                mdio_oe_q <= 1'b0;
                if (rd_q) begin
                  data_o <= shift_q;
                  err_o  <= TA_CHECK && ta_q;
                end
              end else begin
                bit_cnt    <= bit_cnt + 6'd1;
                state      <= phase_of(bit_cnt + 6'd1);
                mdio_out_q <= frame_bit(bit_cnt + 6'd1, rd_q, phy_q, reg_q, wdata_q);
                mdio_oe_q  <= frame_oe(bit_cnt + 6'd1, rd_q);
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_master.sv
// ---------------------------------------------------------------------------
// tb_mdio_master
//   Directed bench for mdio_master at CLK_DIV=2. It uses three instances:
//   u_dut (32-bit preamble, TA check) with a small PHY model on its bus;
//   u_nocheck (TA_CHECK=0), whose bus has only a pull-up;
//   u_nopre (PREAMBLE_LEN=0), whose bus also has only a pull-up.
//   The bench records the bits seen on each rising MDC edge and compares
//   them with hand-built frames.
// ---------------------------------------------------------------------------
module tb_mdio_master;

  localparam int CLK_DIV = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  start_v;
  logic        mode;
  logic [4:0]  phy_addr;
  logic [4:0]  reg_addr;
  logic [15:0] wdata;
  logic [2:0]  ready_v, done_v, err_v, mdc_v;
  logic [15:0] rdata0, rdata1, rdata2;
  wire         mdio0, mdio1, mdio2;

  pullup (mdio0);
  pullup (mdio1);
  pullup (mdio2);

  int total = 0;
  int bad   = 0;

  // PHY model and monitor state
  logic        phy_en   = 1'b0;
  logic [15:0] phy_data = 16'h0;
  logic        phy_oe   = 1'b0;
  logic        phy_bit  = 1'b1;
  int          phy_idx  = 0;
  logic [63:0] cap0 = '0;
  logic [63:0] cap1 = '0;
  logic [31:0] cap2 = '0;
  logic        mdc_prev0 = 1'b0, mdc_prev1 = 1'b0, mdc_prev2 = 1'b0;
  int          last_rise0 = -1;
  int          per_bad  = 0;
  int          done_cnt = 0;
  int          oe_cnt   = 0;
  int          cyc      = 0;

  assign mdio0 = phy_oe ? phy_bit : 1'bz;

  always #5 clk = ~clk;

  mdio_master #(.CLK_DIV(CLK_DIV), .PREAMBLE_LEN(32), .TA_CHECK(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_v[0]), .mode_i(mode),
    .phy_addr_i(phy_addr), .reg_addr_i(reg_addr), .data_i(wdata),
    .ready_o(ready_v[0]), .done_o(done_v[0]), .err_o(err_v[0]),
    .data_o(rdata0), .mdc_o(mdc_v[0]), .mdio_io(mdio0));

  mdio_master #(.CLK_DIV(CLK_DIV), .PREAMBLE_LEN(32), .TA_CHECK(1'b0)) u_nocheck (
    .clk(clk), .rst_n(rst_n), .start_i(start_v[1]), .mode_i(mode),
    .phy_addr_i(phy_addr), .reg_addr_i(reg_addr), .data_i(wdata),
    .ready_o(ready_v[1]), .done_o(done_v[1]), .err_o(err_v[1]),
    .data_o(rdata1), .mdc_o(mdc_v[1]), .mdio_io(mdio1));

  mdio_master #(.CLK_DIV(CLK_DIV), .PREAMBLE_LEN(0), .TA_CHECK(1'b1)) u_nopre (
    .clk(clk), .rst_n(rst_n), .start_i(start_v[2]), .mode_i(mode),
    .phy_addr_i(phy_addr), .reg_addr_i(reg_addr), .data_i(wdata),
    .ready_o(ready_v[2]), .done_o(done_v[2]), .err_o(err_v[2]),
    .data_o(rdata2), .mdc_o(mdc_v[2]), .mdio_io(mdio2));

  // Free-running clk counter, used to measure the spacing of MDC rises.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor and PHY model, evaluated away from the active edge. On each MDC
  // rise the line value is pushed into a capture register. For u_dut the
  // PHY then sets up its reply for the next bit: TA2 = 0, then 16 data bits.
  always @(negedge clk) begin
    if (mdc_v[0] && !mdc_prev0) begin
      cap0 = {cap0[62:0], mdio0};
      if (last_rise0 >= 0 && (cyc - last_rise0) != 2 * CLK_DIV) per_bad++;
      last_rise0 = cyc;
      phy_idx++;
    end
    if (ready_v[0]) begin
      phy_idx    = 0;
      last_rise0 = -1;
    end
    mdc_prev0 = mdc_v[0];
    if (done_v[0]) done_cnt++;
    if (u_dut.mdio_oe_q) oe_cnt++;
    phy_oe  = 1'b0;
    phy_bit = 1'b1;
    if (phy_en && !ready_v[0]) begin
      if (phy_idx == 47) begin
        phy_oe  = 1'b1;
        phy_bit = 1'b0;
      end else if (phy_idx >= 48 && phy_idx <= 63) begin
        phy_oe  = 1'b1;
        phy_bit = phy_data[63 - phy_idx];
      end
    end
    if (mdc_v[1] && !mdc_prev1) cap1 = {cap1[62:0], mdio1};
    mdc_prev1 = mdc_v[1];
    if (mdc_v[2] && !mdc_prev2) cap2 = {cap2[30:0], mdio2};
    mdc_prev2 = mdc_v[2];
  end

  // Runaway guard so the bench always terminates.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Called at a negedge: present a request to one instance.
  task automatic applyStimulus(input int inst, input logic rd, input logic [4:0] pa,
                               input logic [4:0] ra, input logic [15:0] d);
    mode          = rd;
    phy_addr      = pa;
    reg_addr      = ra;
    wdata         = d;
    start_v[inst] = 1'b1;
  endtask

  // Count negedges from the accept until done is seen. The returned latency
  // equals the number of posedges after accept at which done_o is high.
  task automatic waitDone(input int inst, input bit hold, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!hold && !done_v[inst]) start_v[inst] = 1'b0;
    end while (!done_v[inst] && lat < 1000);
    checkOutput("done_seen", 64'(done_v[inst]), 64'd1);
  endtask

  int lat, lat2, oe0, per0, dn0;

  initial begin
    rst_n    = 1'b0;
    start_v  = 3'b000;
    mode     = 1'b0;
    phy_addr = 5'd0;
    reg_addr = 5'd0;
    wdata    = 16'h0;
    repeat (3) @(negedge clk);

    checkOutput("rst_ready", 64'(ready_v[0]), 64'd1);
    checkOutput("rst_done",  64'(done_v[0]),  64'd0);
    checkOutput("rst_err",   64'(err_v[0]),   64'd0);
    checkOutput("rst_data",  64'(rdata0),     64'd0);
    checkOutput("rst_mdc",   64'(mdc_v[0]),   64'd0);
    checkOutput("rst_oe",    64'(u_dut.mdio_oe_q), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write, start held through the whole frame
    oe0 = oe_cnt; per0 = per_bad; dn0 = done_cnt;
    applyStimulus(0, 1'b0, 5'd1, 5'd0, 16'h1140);
    waitDone(0, 1'b1, lat);
    checkOutput("wr_ready_in_done", 64'(ready_v[0]), 64'd1);
    start_v[0] = 1'b0;
    checkOutput("wr_latency", 64'(lat), 64'd257);
    checkOutput("wr_frame", cap0,
                {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd1, 5'd0, 2'b10, 16'h1140});
    checkOutput("wr_err", 64'(err_v[0]), 64'd0);
    checkOutput("wr_mdc_period", 64'(per_bad - per0), 64'd0);
    checkOutput("wr_oe_cycles", 64'(oe_cnt - oe0), 64'd256);
    repeat (40) @(negedge clk);
    checkOutput("held_start_one_frame", 64'(done_cnt - dn0), 64'd1);
    checkOutput("held_start_ready", 64'(ready_v[0]), 64'd1);

    // Read with the PHY model answering
    phy_en = 1'b1; phy_data = 16'h796D;
    @(negedge clk);
    oe0 = oe_cnt;
    applyStimulus(0, 1'b1, 5'd3, 5'd2, 16'h0);
    waitDone(0, 1'b0, lat);
    checkOutput("rd_latency", 64'(lat), 64'd257);
    checkOutput("rd_data", 64'(rdata0), 64'h796D);
    checkOutput("rd_err", 64'(err_v[0]), 64'd0);
    checkOutput("rd_frame", cap0,
                {32'hFFFF_FFFF, 2'b01, 2'b10, 5'd3, 5'd2, 2'b10, 16'h796D});
    checkOutput("rd_oe_cycles", 64'(oe_cnt - oe0), 64'd184);
    phy_en = 1'b0;
    repeat (3) @(negedge clk);

    // Read with no PHY: the pull-up returns all ones
    applyStimulus(0, 1'b1, 5'd3, 5'd2, 16'h0);
    waitDone(0, 1'b0, lat);
    checkOutput("nophy_err", 64'(err_v[0]), 64'd1);
    checkOutput("nophy_data", 64'(rdata0), 64'hFFFF);
    repeat (3) @(negedge clk);
    checkOutput("err_held", 64'(err_v[0]), 64'd1);

    // Same read on the instance with no TA check
    applyStimulus(1, 1'b1, 5'd3, 5'd2, 16'h0);
    waitDone(1, 1'b0, lat);
    checkOutput("nocheck_latency", 64'(lat), 64'd257);
    checkOutput("nocheck_err", 64'(err_v[1]), 64'd0);
    checkOutput("nocheck_data", 64'(rdata1), 64'hFFFF);
    checkOutput("nocheck_frame", cap1,
                {32'hFFFF_FFFF, 2'b01, 2'b10, 5'd3, 5'd2, 2'b11, 16'hFFFF});
    repeat (3) @(negedge clk);

    // Write with no preamble
    applyStimulus(2, 1'b0, 5'h1F, 5'h0A, 16'hA5C3);
    waitDone(2, 1'b0, lat);
    checkOutput("nopre_latency", 64'(lat), 64'd129);
    checkOutput("nopre_frame", 64'(cap2),
                64'({2'b01, 2'b01, 5'h1F, 5'h0A, 2'b10, 16'hA5C3}));
    repeat (3) @(negedge clk);

    // Back-to-back writes: the second request arrives in the done cycle
    applyStimulus(0, 1'b0, 5'h12, 5'h04, 16'h0F0F);
    waitDone(0, 1'b0, lat);
    checkOutput("b2b_first_frame", cap0,
                {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h12, 5'h04, 2'b10, 16'h0F0F});
    applyStimulus(0, 1'b0, 5'h07, 5'h1B, 16'hBEEF);
    waitDone(0, 1'b0, lat2);
    checkOutput("b2b_first_latency", 64'(lat), 64'd257);
    checkOutput("b2b_second_latency", 64'(lat2), 64'd257);
    checkOutput("b2b_second_frame", cap0,
                {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h07, 5'h1B, 2'b10, 16'hBEEF});
    repeat (3) @(negedge clk);

    // Reset in the middle of the DATA field
    dn0 = done_cnt;
    applyStimulus(0, 1'b0, 5'h05, 5'h06, 16'h1234);
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (199) @(negedge clk);
    checkOutput("mid_busy", 64'(ready_v[0]), 64'd0);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_ready", 64'(ready_v[0]), 64'd1);
    checkOutput("midrst_mdc",   64'(mdc_v[0]),   64'd0);
    checkOutput("midrst_oe",    64'(u_dut.mdio_oe_q), 64'd0);
    checkOutput("midrst_done",  64'(done_v[0]),  64'd0);
    checkOutput("midrst_data",  64'(rdata0),     64'd0);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    checkOutput("midrst_no_done", 64'(done_cnt - dn0), 64'd0);
    checkOutput("midrst_idle", 64'(ready_v[0]), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
